// File: rtl/sabana_add_sched_if.sv
// Queue-side bundle for sabana_add_sched: A/B pop ports and Y push port.
interface sabana_add_sched_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] a_in;
  logic              a_empty;
  logic              a_pop;
  logic [DATA_W-1:0] b_in;
  logic              b_empty;
  logic              b_pop;
  logic [DATA_W-1:0] y_out;
  logic              y_push;
  logic              y_full;

  modport master (
    input  a_in, a_empty, b_in, b_empty, y_full,
    output a_pop, b_pop, y_out, y_push
  );

  modport slave (
    output a_in, a_empty, b_in, b_empty, y_full,
    input  a_pop, b_pop, y_out, y_push
  );
endinterface

// File: rtl/sabana_add_sched.sv
// Two-queue add job sequencer with a registered Y stage and backpressure.
// Optional no-progress watchdog with error port: define SABANA_ADD_SCHED_TIMEOUT_EN.
module sabana_add_sched #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] count,
  sabana_add_sched_if.master q
`ifdef SABANA_ADD_SCHED_TIMEOUT_EN
  ,
  output logic             error
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  remaining_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] out_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              finish_r;
  logic              fire_s;
  logic              xfer_s;
  logic              start_ok_s;
  logic              timeout_s;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sabana_add_sched: TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake decode and next-state logic
  always_comb begin
    state_s    = state_r;
    start_ok_s = (state_r == IDLE) && start;
    xfer_s     = out_valid_r && !q.y_full;
    // A new pair may load only when the output slot is free or draining this cycle.
    fire_s     = (state_r == RUN) && (remaining_r != CNT_ZERO) && !q.a_empty && !q.b_empty
                 && (!out_valid_r || !q.y_full);
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (timeout_s) begin
          state_s = DONE;
        end else if (fire_s && (remaining_r == CNT_ONE)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (timeout_s || !out_valid_r || xfer_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state, host-facing status and job counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      finish_r    <= 1'b0;
      remaining_r <= CNT_ZERO;
      count_r     <= CNT_ZERO;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s != IDLE);
      finish_r <= (state_s == DONE);
      if (start_ok_s) begin
        remaining_r <= len;
      end else if (fire_s) begin
        remaining_r <= remaining_r - CNT_ONE;
      end
      if (start_ok_s) begin
        count_r <= CNT_ZERO;
      end else if (xfer_s) begin
        count_r <= count_r + CNT_ONE;
      end
    end
  end

  // Registered sum stage; holds its value while Y is full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_r       <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (fire_s) begin
        out_r <= q.a_in + q.b_in;
      end
      if (timeout_s) begin
        out_valid_r <= 1'b0;
      end else if (fire_s) begin
        out_valid_r <= 1'b1;
      end else if (xfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef SABANA_ADD_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_r;
  logic               error_r;

  // Watchdog fires on the cycle that would complete TIMEOUT_CYCLES idle cycles
  always_comb begin
    timeout_s = ((state_r == RUN) || (state_r == DRAIN)) && !fire_s && !xfer_s
                && (stall_r == STALL_LIM);
  end

  // No-progress counter and sticky error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_r <= {STALL_W{1'b0}};
      error_r <= 1'b0;
    end else begin
      if (((state_r == RUN) || (state_r == DRAIN)) && !fire_s && !xfer_s) begin
        stall_r <= stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
      end else begin
        stall_r <= {STALL_W{1'b0}};
      end
      if (start_ok_s) begin
        error_r <= 1'b0;
      end else if (timeout_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign error = error_r;
`else
  assign timeout_s = 1'b0;
`endif

  assign busy     = busy_r;
  assign finish   = finish_r;
  assign count    = count_r;
  assign q.a_pop  = fire_s;
  assign q.b_pop  = fire_s;
  assign q.y_out  = out_r;
  assign q.y_push = out_valid_r;

endmodule

// File: doc/sabana_add_sched.md
Name: sabana_add_sched

Overview:
- Controller that sequences a two-queue add job: pops element pairs from input queues A and B, adds them, and pushes sums to output queue Y for exactly `len` elements.
- Adds a registered output stage and proper backpressure.
- Reports busy/finish/count to the host control shell.
- Sits between the host start/finish interface and the three queue ports of the accelerator.

Parameters:
- DATA_W, 32, width of queue data and of the sum.
- CNT_W, 16, width of the job length and element counters.
- TIMEOUT_CYCLES, 1024, no-progress limit; used only with the optional feature.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; honoured only in IDLE.
- len  in  CNT_W  element count; sampled when start is honoured.
- busy  out  1  high whenever state != IDLE.
- finish  out  1  one-cycle pulse at job end.
- count  out  CNT_W  sums accepted by Y in the current/last job.
- a_in  in  DATA_W  head of queue A; valid when a_empty=0.
- a_empty  in  1  queue A empty.
- a_pop  out  1  consume head of A this cycle.
- b_in  in  DATA_W  head of queue B.
- b_empty  in  1  queue B empty.
- b_pop  out  1  consume head of B this cycle.
- y_out  out  DATA_W  registered sum.
- y_push  out  1  y_out valid; transfer occurs when y_push=1 and y_full=0.
- y_full  in  1  queue Y full.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; remaining, count, output register and out_valid cleared.
  - All outputs 0: busy, finish, a_pop, b_pop, y_push, y_out, count.
  - Queue contents are untouched.
- Definitions:
  - xfer = y_push & ~y_full.
  - fire = (state==RUN) & (remaining!=0) & ~a_empty & ~b_empty & (~out_valid | ~y_full).
  - a_pop = b_pop = fire; combinational, A and B always popped together.
- Datapath:
  - On fire, out_reg <= a_in + b_in, truncated modulo 2^DATA_W (carry discarded); out_valid <= 1.
  - On xfer without fire, out_valid <= 0.
  - y_out = out_reg; y_push = out_valid.
  - y_out stays stable while y_push=1 and y_full=1.
  - Latency from pop to y_push is 1 cycle.
  - Throughput is 1 element/cycle when no queue stalls.
- count: cleared when start is honoured; increments on each xfer; holds after finish until the next honoured start.
- FSM:
  - IDLE: on start with len!=0, latch remaining=len and go to RUN. On start with len==0, go to DONE with no pops.
  - RUN: each fire decrements remaining. A fire with remaining==1 goes to DRAIN.
  - DRAIN: no pops. When out_valid==0, or xfer occurs this cycle, go to DONE.
  - DONE: finish=1 for exactly this cycle, then IDLE.
- Boundary conditions:
  - start outside IDLE is ignored; len changes outside IDLE are ignored.
  - Only one of A/B non-empty: no pop of either; waits indefinitely (unless the optional feature is enabled).
  - y_full while out_valid: no pops, so no data loss.
  - y_full deasserting and a new fire in the same cycle: old value transfers, new value loads, out_valid stays 1.
  - finish is decoded from a state register and is glitch-free.

Optional Feature:
- Macro: SABANA_ADD_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output port `error` (1 bit).
  - A stall counter runs in RUN/DRAIN. It clears on any fire or xfer and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE (finish pulse), set error=1 and drop out_valid.
  - error holds until the next honoured start or reset.
- When undefined: no error port, no counter; the FSM waits forever for data or space.

Test Plan:
1. Basic job: len=4, A={1,2,3,4}, B={10,20,30,40}, y_full=0, start at cycle 0 -> pops in cycles 1-4; y_push with 11,22,33,44 in cycles 2-5; finish only in cycle 6; count=4; busy high cycles 1-6.
2. Backpressure: as test 1 with y_full=1 in cycles 3-5 -> y_out holds 22 through the stall; no pops in cycles 3-5; all four sums delivered in order; count=4.
3. Zero length: start with len=0 -> one finish pulse the next cycle; a_pop/b_pop/y_push never asserted; count=0.
4. Unbalanced queues: len=2, A non-empty, B empty for 5 cycles then B={7,8} with A={0xFFFFFFFF,1} -> no pops while B empty; outputs 0x00000006 (carry dropped) then 9.
5. Reset mid-job: len=8, reset=0 after 3 fires -> all outputs 0 immediately without waiting for a clock edge; after release a new start with len=1 completes normally.
6. Timeout (macro defined, TIMEOUT_CYCLES=16): len=2, A/B empty after start -> finish exactly 16 cycles after entering RUN; error=1; error clears on the next start.
